norm_sft: RTL and testbench



---
 rtl/norm_pkg.sv | 14 +
 rtl/bit_rev32.sv | 16 +
 rtl/norm_sft.sv | 151 +++++++++++++++
 tb/tb_norm_sft.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/norm_pkg.sv
// Shared types and constants for the norm_sft leading/trailing-zero normalizer.
package norm_pkg;

    localparam int unsigned NORM_W     = 32;
    localparam int unsigned NORM_CNT_W = 6;
    localparam int unsigned NORM_STEPS = 5;

    typedef enum logic [1:0] {
        NORM_IDLE = 2'd0,
        NORM_RUN  = 2'd1,
        NORM_DONE = 2'd2
    } norm_state_e;

endpackage

// File: rtl/bit_rev32.sv
// Combinational 32-bit bit reversal. It is used to run trailing-zero mode
// through the leading-zero search.
module bit_rev32
    import norm_pkg::*;
(
    input  logic [NORM_W-1:0] i_data,
    output logic [NORM_W-1:0] o_data
);

    always_comb begin
        for (int i = 0; i < NORM_W; i++) begin
            o_data[i] = i_data[NORM_W-1-i];
        end
    end

endmodule

// File: rtl/norm_sft.sv
// Multi-cycle normalizer: a 5-step binary search for the leading one, one step per clock.
// The optional macro NORM_CTZ_EN enables trailing-zero mode through norm_tz.
module norm_sft
    import norm_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NORM_W-1:0]     norm_in,
    input  logic                  norm_start,
    input  logic                  norm_tz,
    output logic                  norm_busy,
    output logic                  norm_done,
    output logic [NORM_W-1:0]     norm_out,
    output logic [NORM_CNT_W-1:0] norm_cnt,
    output logic                  norm_zero
);

    norm_state_e           r_state;
    logic [NORM_W-1:0]     r_work;
    logic [NORM_CNT_W-1:0] r_cnt;
    logic [2:0]            r_step;
    logic                  r_zero;
    logic [NORM_W-1:0]     r_out;
    logic [NORM_CNT_W-1:0] r_cnt_out;
    logic                  r_zero_out;

    logic [NORM_W-1:0]     w_cap;
    logic [NORM_W-1:0]     w_res;
    logic [NORM_W-1:0]     w_shifted;
    logic [NORM_W-1:0]     w_work_nxt;
    logic [NORM_CNT_W-1:0] w_shamt;
    logic [NORM_CNT_W-1:0] w_cnt_nxt;
    logic                  w_top_zero;
    logic                  w_last_step;

`ifdef NORM_CTZ_EN
    logic              r_tz;
    logic [NORM_W-1:0] w_in_rev;
    logic [NORM_W-1:0] w_work_rev;

    bit_rev32 u_rev_in (
        .i_data (norm_in),
        .o_data (w_in_rev)
    );

    bit_rev32 u_rev_out (
        .i_data (w_work_nxt),
        .o_data (w_work_rev)
    );

    assign w_cap = norm_tz ? w_in_rev : norm_in;
    assign w_res = r_tz ? w_work_rev : w_work_nxt;
`else
    // Port kept for a uniform instantiation; the value is not used.
    logic w_tz_unused;
    assign w_tz_unused = norm_tz;
    assign w_cap       = norm_in;
    assign w_res       = w_work_nxt;
`endif

    // One search step: shift by 16, 8, 4, 2, 1 when the top bits are all zero.
    always_comb begin
        w_top_zero = 1'b0;
        w_shifted  = r_work;
        w_shamt    = '0;
        case (r_step)
            3'd0: begin
                w_top_zero = (r_work[31:16] == 16'h0);
                w_shifted  = {r_work[15:0], 16'h0};
                w_shamt    = 6'd16;
            end
            3'd1: begin
                w_top_zero = (r_work[31:24] == 8'h0);
                w_shifted  = {r_work[23:0], 8'h0};
                w_shamt    = 6'd8;
            end
            3'd2: begin
                w_top_zero = (r_work[31:28] == 4'h0);
                w_shifted  = {r_work[27:0], 4'h0};
                w_shamt    = 6'd4;
            end
            3'd3: begin
                w_top_zero = (r_work[31:30] == 2'h0);
                w_shifted  = {r_work[29:0], 2'h0};
                w_shamt    = 6'd2;
            end
            3'd4: begin
                w_top_zero = ~r_work[31];
                w_shifted  = {r_work[30:0], 1'b0};
                w_shamt    = 6'd1;
            end
            default: ;
        endcase
        w_work_nxt = w_top_zero ? w_shifted : r_work;
        w_cnt_nxt  = w_top_zero ? (r_cnt + w_shamt) : r_cnt;
    end

    assign w_last_step = (r_step == 3'(NORM_STEPS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= NORM_IDLE;
            r_work     <= '0;
            r_cnt      <= '0;
            r_step     <= '0;
            r_zero     <= 1'b0;
            r_out      <= '0;
            r_cnt_out  <= '0;
            r_zero_out <= 1'b0;
`ifdef NORM_CTZ_EN
            r_tz       <= 1'b0;
`endif
        end else begin
            case (r_state)
                NORM_RUN: begin
                    r_work <= w_work_nxt;
                    r_cnt  <= w_cnt_nxt;
                    r_step <= r_step + 3'd1;
                    if (w_last_step) begin
                        r_state    <= NORM_DONE;
                        r_out      <= w_res;
                        // A zero operand searches to 31; report the full width instead.
                        r_cnt_out  <= r_zero ? 6'(NORM_W) : w_cnt_nxt;
                        r_zero_out <= r_zero;
                    end
                end
                default: begin
                    if (norm_start) begin
                        r_state <= NORM_RUN;
                        r_work  <= w_cap;
                        r_cnt   <= '0;
                        r_step  <= '0;
                        r_zero  <= (norm_in == '0);
`ifdef NORM_CTZ_EN
                        r_tz    <= norm_tz;
`endif
                    end else begin
                        r_state <= NORM_IDLE;
                    end
                end
            endcase
        end
    end

    assign norm_busy = (r_state == NORM_RUN);
    assign norm_done = (r_state == NORM_DONE);
    assign norm_out  = r_out;
    assign norm_cnt  = r_cnt_out;
    assign norm_zero = r_zero_out;

endmodule

// File: tb/tb_norm_sft.sv
// Directed-vector bench for norm_sft: table-driven normal requests plus
// sequences for the ignored start, back-to-back start, and the mid-search reset.
module tb_norm_sft;

    logic        clk;
    logic        rst;
    logic [31:0] norm_in;
    logic        norm_start;
    logic        norm_tz;
    logic        norm_busy;
    logic        norm_done;
    logic [31:0] norm_out;
    logic [5:0]  norm_cnt;
    logic        norm_zero;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [31:0] din;
        logic        tz;
        logic [5:0]  cnt;
        logic [31:0] dout;
        logic        zero;
    } vec_t;

    vec_t vecs[8];

    norm_sft u_dut (
        .clk        (clk),
        .rst        (rst),
        .norm_in    (norm_in),
        .norm_start (norm_start),
        .norm_tz    (norm_tz),
        .norm_busy  (norm_busy),
        .norm_done  (norm_done),
        .norm_out   (norm_out),
        .norm_cnt   (norm_cnt),
        .norm_zero  (norm_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t, limit 200000", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Presents a request in cycle 0; returns at cycle 1 (+1 time unit).
    task automatic start_req(input logic [31:0] d, input logic tz);
        @(posedge clk); #1;
        norm_in    = d;
        norm_tz    = tz;
        norm_start = 1'b1;
        @(posedge clk); #1;
        norm_start = 1'b0;
    endtask

    task automatic run_vec(input logic [31:0] d, input logic tz, input logic [5:0] ecnt,
                           input logic [31:0] eout, input logic ezero, input string tag);
        logic [31:0] prev_out;
        int          busy_n;
        int          bad;
        start_req(d, tz);
        prev_out = norm_out;
        busy_n   = 0;
        bad      = 0;
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) begin
                @(posedge clk); #1;
            end
            if (norm_busy) busy_n++;
            if (norm_done || norm_out !== prev_out) bad++;
        end
        @(posedge clk); #1;
        check({tag, " busy cycles"}, busy_n, 5);
        check({tag, " hold during run"}, bad, 0);
        check({tag, " done"}, {31'b0, norm_done}, 1);
        check({tag, " busy at done"}, {31'b0, norm_busy}, 0);
        check({tag, " cnt"}, {26'b0, norm_cnt}, {26'b0, ecnt});
        check({tag, " out"}, norm_out, eout);
        check({tag, " zero"}, {31'b0, norm_zero}, {31'b0, ezero});
        @(posedge clk); #1;
        check({tag, " done one cycle"}, {31'b0, norm_done}, 0);
    endtask

    initial begin
        int n_done;

        vecs[0] = '{32'h0000_0001, 1'b0, 6'd31, 32'h8000_0000, 1'b0};
        vecs[1] = '{32'h8000_0000, 1'b0, 6'd0,  32'h8000_0000, 1'b0};
        vecs[2] = '{32'h0000_0000, 1'b0, 6'd32, 32'h0000_0000, 1'b1};
        vecs[3] = '{32'hFFFF_FFFF, 1'b0, 6'd0,  32'hFFFF_FFFF, 1'b0};
        vecs[4] = '{32'h0000_0A00, 1'b0, 6'd20, 32'hA000_0000, 1'b0};
        vecs[5] = '{32'h4000_0000, 1'b0, 6'd1,  32'h8000_0000, 1'b0};
`ifdef NORM_CTZ_EN
        vecs[6] = '{32'h0000_0A00, 1'b1, 6'd9,  32'h0000_0005, 1'b0};
`else
        vecs[6] = '{32'h0000_0A00, 1'b1, 6'd20, 32'hA000_0000, 1'b0};
`endif
        vecs[7] = '{32'h0000_0000, 1'b1, 6'd32, 32'h0000_0000, 1'b1};

        rst        = 1'b1;
        norm_in    = '0;
        norm_start = 1'b0;
        norm_tz    = 1'b0;
        #2;
        check("reset busy", {31'b0, norm_busy}, 0);
        check("reset done", {31'b0, norm_done}, 0);
        check("reset out", norm_out, 0);
        check("reset cnt", {26'b0, norm_cnt}, 0);
        check("reset zero", {31'b0, norm_zero}, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i].din, vecs[i].tz, vecs[i].cnt, vecs[i].dout, vecs[i].zero,
                    $sformatf("vec%0d", i));
        end

        // Start while busy is dropped, not queued.
        start_req(32'h0001_2345, 1'b0);
        @(posedge clk); #1;
        norm_in    = 32'hFFFF_FFFF;
        norm_start = 1'b1;
        @(posedge clk); #1;
        norm_start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("busy-start done", {31'b0, norm_done}, 1);
        check("busy-start cnt", {26'b0, norm_cnt}, 15);
        check("busy-start out", norm_out, 32'h91A2_8000);
        n_done = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (norm_done || norm_busy) n_done++;
        end
        check("busy-start not queued", n_done, 0);

        // Start in the done cycle is accepted.
        start_req(32'h0000_0001, 1'b0);
        repeat (5) begin
            @(posedge clk); #1;
        end
        check("b2b first done", {31'b0, norm_done}, 1);
        norm_in    = 32'h00F0_0000;
        norm_start = 1'b1;
        @(posedge clk); #1;
        norm_start = 1'b0;
        check("b2b second busy", {31'b0, norm_busy}, 1);
        check("b2b first out held", norm_out, 32'h8000_0000);
        repeat (5) begin
            @(posedge clk); #1;
        end
        check("b2b second done", {31'b0, norm_done}, 1);
        check("b2b second cnt", {26'b0, norm_cnt}, 8);
        check("b2b second out", norm_out, 32'hF000_0000);

        // Reset mid-search clears outputs at once and suppresses done.
        start_req(32'h0000_00FF, 1'b0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        check("abort out", norm_out, 0);
        check("abort cnt", {26'b0, norm_cnt}, 0);
        check("abort busy", {31'b0, norm_busy}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        n_done = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (norm_done) n_done++;
        end
        check("abort no done", n_done, 0);
        run_vec(32'h0000_00FF, 1'b0, 6'd24, 32'hFF00_0000, 1'b0, "restart");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
